fast_square_sweep_sequencer: RTL and testbench

//  Sequences one RX frequency sweep. Steps through a programmable table of synthesizer tuning

---
 rtl/fast_square_sweep_sequencer.sv | 258 +++++++++++++++++++++++++
 tb/tb_fast_square_sweep_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_square_sweep_sequencer.sv
// RX sweep sequencer: tunes the synthesizer per table step, waits for settled lock, records.
// Optional lock-timeout/ERROR support is built when FSQ_LOCK_TIMEOUT_EN is defined.
module fast_square_sweep_sequencer #(
  parameter int unsigned NUM_STEPS    = 32,
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned DWELL_W      = 16,
  parameter int unsigned SETTLE_TICKS = 640
`ifdef FSQ_LOCK_TIMEOUT_EN
  ,
  parameter int unsigned LOCK_TIMEOUT = 65535
`endif
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         loop_en,
  input  logic [DWELL_W-1:0]           dwell_ticks,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
  input  logic [WORD_W-1:0]            cfg_word,
  output logic                         synth_req,
  output logic [WORD_W-1:0]            synth_word,
  input  logic                         synth_ack,
  input  logic                         pll_locked,
  output logic                         rx_reset,
  output logic                         rx_record,
  output logic                         rx_next,
  output logic                         busy,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         sweep_done,
  output logic                         lock_err
);

  localparam int unsigned AW = $clog2(NUM_STEPS);
  localparam int unsigned SW = $clog2(SETTLE_TICKS + 1);
  localparam logic [AW-1:0] LastStep = AW'(NUM_STEPS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLock,
    StRecord,
    StNext
`ifdef FSQ_LOCK_TIMEOUT_EN
    ,
    StError
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       step_q, step_d;
  logic                synth_req_q, synth_req_d;
  logic [WORD_W-1:0]   synth_word_q, synth_word_d;
  logic                rx_reset_q, rx_reset_d;
  logic                rx_record_q, rx_record_d;
  logic                rx_next_q, rx_next_d;
  logic                busy_q, busy_d;
  logic                sweep_done_q, sweep_done_d;
  logic [SW-1:0]       lock_cnt_q, lock_cnt_d;
  logic [DWELL_W-1:0]  rec_cnt_q, rec_cnt_d;
  logic                launch;
  logic                tbl_we;
  logic [WORD_W-1:0]   tbl_q [NUM_STEPS];

`ifdef FSQ_LOCK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                lock_err_q, lock_err_d;
  assign tbl_we = cfg_we && (state_q == StIdle || state_q == StError) &&
                  (32'(cfg_addr) < NUM_STEPS);
`else
  assign tbl_we = cfg_we && (state_q == StIdle) && (32'(cfg_addr) < NUM_STEPS);
`endif

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    synth_req_d  = synth_req_q;
    synth_word_d = synth_word_q;
    rx_reset_d   = 1'b0;
    rx_record_d  = rx_record_q;
    rx_next_d    = 1'b0;
    sweep_done_d = 1'b0;
    lock_cnt_d   = lock_cnt_q;
    rec_cnt_d    = rec_cnt_q;
    launch       = 1'b0;
`ifdef FSQ_LOCK_TIMEOUT_EN
    tmo_d        = tmo_q;
    lock_err_d   = lock_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        rx_reset_d = 1'b1;
        launch     = start;
      end
`ifdef FSQ_LOCK_TIMEOUT_EN
      StError: begin
        rx_reset_d = 1'b1;
        launch     = start;
      end
`endif
      StLoad: begin
        synth_req_d = 1'b1;
        if (synth_ack) begin
          synth_req_d = 1'b0;
          state_d     = StLock;
          lock_cnt_d  = '0;
`ifdef FSQ_LOCK_TIMEOUT_EN
          tmo_d       = '0;
`endif
        end
      end
      StLock: begin
        if (!pll_locked) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == SW'(SETTLE_TICKS - 1)) begin
          state_d     = StRecord;
          rx_record_d = 1'b1;
          // Zero dwell is treated as a one-cycle window.
          rec_cnt_d   = (dwell_ticks == '0) ? DWELL_W'(1) : dwell_ticks;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
`ifdef FSQ_LOCK_TIMEOUT_EN
        tmo_d = tmo_q + 1'b1;
        if (state_d == StLock && tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
          state_d    = StError;
          lock_err_d = 1'b1;
          rx_reset_d = 1'b1;
        end
`endif
      end
      StRecord: begin
        if (!pll_locked) begin
          // Lost lock mid-window: flush the RX path and retune the same step.
          rx_record_d = 1'b0;
          rx_reset_d  = 1'b1;
          synth_req_d = 1'b1;
          state_d     = StLoad;
        end else if (rec_cnt_q == DWELL_W'(1)) begin
          rx_record_d = 1'b0;
          state_d     = StNext;
        end else begin
          rec_cnt_d = rec_cnt_q - 1'b1;
        end
      end
      StNext: begin
        if (step_q != LastStep) begin
          step_d      = step_q + 1'b1;
          rx_next_d   = 1'b1;
          synth_req_d = 1'b1;
          state_d     = StLoad;
        end else begin
          sweep_done_d = 1'b1;
          if (loop_en) begin
            step_d      = '0;
            rx_next_d   = 1'b1;
            synth_req_d = 1'b1;
            state_d     = StLoad;
          end else begin
            rx_reset_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d     = StLoad;
      step_d      = '0;
      synth_req_d = 1'b1;
      rx_reset_d  = 1'b0;
`ifdef FSQ_LOCK_TIMEOUT_EN
      lock_err_d  = 1'b0;
`endif
    end

    if (abort) begin
      state_d      = StIdle;
      synth_req_d  = 1'b0;
      rx_record_d  = 1'b0;
      rx_reset_d   = 1'b1;
      rx_next_d    = 1'b0;
      sweep_done_d = 1'b0;
    end

    if (state_d == StLoad && state_q != StLoad) begin
      synth_word_d = tbl_q[step_d];
    end

`ifdef FSQ_LOCK_TIMEOUT_EN
    busy_d = (state_d != StIdle) && (state_d != StError);
`else
    busy_d = (state_d != StIdle);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      step_q       <= '0;
      synth_req_q  <= 1'b0;
      synth_word_q <= '0;
      rx_reset_q   <= 1'b1;
      rx_record_q  <= 1'b0;
      rx_next_q    <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      lock_cnt_q   <= '0;
      rec_cnt_q    <= '0;
`ifdef FSQ_LOCK_TIMEOUT_EN
      tmo_q        <= '0;
      lock_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      synth_req_q  <= synth_req_d;
      synth_word_q <= synth_word_d;
      rx_reset_q   <= rx_reset_d;
      rx_record_q  <= rx_record_d;
      rx_next_q    <= rx_next_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
      lock_cnt_q   <= lock_cnt_d;
      rec_cnt_q    <= rec_cnt_d;
`ifdef FSQ_LOCK_TIMEOUT_EN
      tmo_q        <= tmo_d;
      lock_err_q   <= lock_err_d;
`endif
    end
  end

  // Table is configuration storage only; it is deliberately not reset.
  always_ff @(posedge clock) begin
    if (tbl_we) begin
      tbl_q[cfg_addr] <= cfg_word;
    end
  end

  assign synth_req  = synth_req_q;
  assign synth_word = synth_word_q;
  assign rx_reset   = rx_reset_q;
  assign rx_record  = rx_record_q;
  assign rx_next    = rx_next_q;
  assign busy       = busy_q;
  assign step_idx   = step_q;
  assign sweep_done = sweep_done_q;
`ifdef FSQ_LOCK_TIMEOUT_EN
  assign lock_err   = lock_err_q;
`else
  assign lock_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fast_square_sweep_sequencer.sv
// Scoreboard bench for fast_square_sweep_sequencer: a stimulus process pushes expected output
// events from a step-level sweep model; a negedge monitor pops and compares observed events.
module tb_fast_square_sweep_sequencer;
  localparam int unsigned NS     = 4;
  localparam int unsigned SETTLE = 8;

  logic        clock = 1'b0;
  logic        reset, start, abort, loop_en, cfg_we, synth_ack, pll_locked;
  logic [15:0] dwell_ticks, cfg_word, synth_word;
  logic [1:0]  cfg_addr, step_idx;
  logic        synth_req, rx_reset, rx_record, rx_next, busy, sweep_done, lock_err;

  always #5 clock = ~clock;

  fast_square_sweep_sequencer #(
    .NUM_STEPS    (NS),
    .WORD_W       (16),
    .DWELL_W      (16),
    .SETTLE_TICKS (SETTLE)
`ifdef FSQ_LOCK_TIMEOUT_EN
    ,
    .LOCK_TIMEOUT (20)
`endif
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .loop_en     (loop_en),
    .dwell_ticks (dwell_ticks),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_word    (cfg_word),
    .synth_req   (synth_req),
    .synth_word  (synth_word),
    .synth_ack   (synth_ack),
    .pll_locked  (pll_locked),
    .rx_reset    (rx_reset),
    .rx_record   (rx_record),
    .rx_next     (rx_next),
    .busy        (busy),
    .step_idx    (step_idx),
    .sweep_done  (sweep_done),
    .lock_err    (lock_err)
  );

  localparam logic [3:0] EvReq = 4'd1, EvSet = 4'd2, EvRec = 4'd3, EvPulse = 4'd4, EvRst = 4'd5;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  logic [15:0] model_tbl [NS];
  bit          mon_en = 1'b0;

  function automatic logic [31:0] ev(logic [3:0] k, logic [27:0] d);
    return {k, d};
  endfunction

  function automatic logic [31:0] req_ev(int s);
    return ev(EvReq, {10'd0, 2'(s), model_tbl[s]});
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic emit(logic [31:0] act);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got %0h expected none", act);
    end else begin
      check("event", act, exp_q.pop_front());
    end
  endtask

  // Monitor: turns output waveforms into events (window lengths, settle runs, pulses, requests).
  logic prev_req = 1'b0, prev_rec = 1'b0, prev_rst = 1'b1;
  int   run = 0, rec_len = 0;
  always @(negedge clock) begin
    if (mon_en) begin
      if (!rx_record && prev_rec) emit(ev(EvRec, 28'(rec_len)));
      if (rx_record && !prev_rec) emit(ev(EvSet, 28'(run)));
      if (rx_next || sweep_done) emit(ev(EvPulse, {26'd0, rx_next, sweep_done}));
      if (rx_reset && !prev_rst) emit(ev(EvRst, 28'd0));
      if (synth_req && !prev_req) emit(ev(EvReq, {10'd0, step_idx, synth_word}));
      if (synth_req) run = 0;
      else if (busy && !rx_record) run = pll_locked ? run + 1 : 0;
      rec_len  = rx_record ? rec_len + 1 : 0;
      prev_req = synth_req;
      prev_rec = rx_record;
      prev_rst = rx_reset;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic sig(int k);
    case (k)
      0:       return synth_req;
      1:       return rx_record;
      default: return busy;
    endcase
  endfunction

  task automatic wait_until(int k, logic v, string name);
    int n = 0;
    while (sig(k) !== v && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (sig(k) !== v) begin
      bad++;
      $display("FAIL %s: timed out, got %0b required %0b", name, sig(k), v);
    end
  endtask

  task automatic do_lock(int glitch);
    pll_locked = 1'b1;
    if (glitch > 0) begin
      repeat (glitch) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
    end
  endtask

  // One table step; the REQ for this step is already expected.
  task automatic run_step(int s, bit last, bit loop_nxt, logic [15:0] dw);
    int win  = (dw == 16'd0) ? 1 : int'(dw);
    int drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, win)) : 0;
    if (drop > 0) begin
      exp_q.push_back(ev(EvSet, 28'(SETTLE)));
      exp_q.push_back(ev(EvRec, 28'(drop)));
      exp_q.push_back(ev(EvRst, 28'd0));
      exp_q.push_back(req_ev(s));
    end
    exp_q.push_back(ev(EvSet, 28'(SETTLE)));
    exp_q.push_back(ev(EvRec, 28'(win)));
    if (!last) begin
      exp_q.push_back(ev(EvPulse, 28'd2));
      exp_q.push_back(req_ev(s + 1));
    end else if (loop_nxt) begin
      exp_q.push_back(ev(EvPulse, 28'd3));
      exp_q.push_back(req_ev(0));
    end else begin
      exp_q.push_back(ev(EvPulse, 28'd1));
      exp_q.push_back(ev(EvRst, 28'd0));
    end
    for (int a = 0; a < ((drop > 0) ? 2 : 1); a++) begin
      wait_until(0, 1'b1, "wait_req");
      repeat ($urandom_range(0, 3)) tick();
      synth_ack = 1'b1;
      tick();
      synth_ack = 1'b0;
      do_lock(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, SETTLE - 1)) : 0);
      if ($urandom_range(0, 2) == 0) begin
        // Busy-time start and table write must both be ignored.
        start    = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 2'($urandom_range(0, NS - 1));
        cfg_word = 16'($urandom);
        tick();
        start  = 1'b0;
        cfg_we = 1'b0;
      end
      wait_until(1, 1'b1, "wait_record");
      if (a == 0 && drop > 0) begin
        repeat (drop - 1) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
      end else begin
        wait_until(1, 1'b0, "wait_record_end");
      end
    end
  endtask

  task automatic sweep(bit do_loop, logic [15:0] dw);
    int passes = do_loop ? 2 : 1;
    dwell_ticks = dw;
    loop_en     = do_loop;
    exp_q.push_back(req_ev(0));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < NS; s++) begin
        if (p == 1 && s == 0) begin
          wait_until(0, 1'b1, "wait_req_pass2");
          loop_en = 1'b0;
        end
        run_step(s, s == NS - 1, p < passes - 1, dw);
      end
    end
    wait_until(2, 1'b0, "wait_idle");
    check("end_rx_reset", 32'(rx_reset), 32'd1);
    check("end_step_idx", 32'(step_idx), 32'(NS - 1));
  endtask

  task automatic load_table(bit incr);
    for (int i = 0; i < NS; i++) begin
      model_tbl[i] = incr ? 16'(16'h100 + i) : 16'($urandom);
      cfg_we   = 1'b1;
      cfg_addr = 2'(i);
      cfg_word = model_tbl[i];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0; cfg_we = 1'b0;
    synth_ack = 1'b0; pll_locked = 1'b0; dwell_ticks = 16'd5; cfg_addr = '0; cfg_word = '0;
    #2 reset = 1'b1;
    tick();
    tick();
    check("rst_rx_reset", 32'(rx_reset), 32'd1);
    check("rst_synth_req", 32'(synth_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step_idx", 32'(step_idx), 32'd0);
    check("rst_outputs", {27'd0, rx_record, rx_next, sweep_done, lock_err, 1'b0}, 32'd0);
    reset  = 1'b0;
    tick();
    mon_en = 1'b1;

    load_table(1'b1);
    sweep(1'b0, 16'd5);
    for (int n = 0; n < 6; n++) begin
      load_table(1'b0);
      sweep($urandom_range(0, 2) == 0, 16'($urandom_range(0, 6)));
    end
    load_table(1'b1);
    sweep(1'b1, 16'd0);

    // Abort coincident with ack in LOAD.
    exp_q.push_back(req_ev(0));
    exp_q.push_back(ev(EvRst, 28'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(0, 1'b1, "abort_wait_req");
    tick();
    abort     = 1'b1;
    synth_ack = 1'b1;
    tick();
    abort     = 1'b0;
    synth_ack = 1'b0;
    check("abort_synth_req", 32'(synth_req), 32'd0);
    check("abort_rx_reset", 32'(rx_reset), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx_next", 32'(rx_next), 32'd0);

    // Abort in the middle of a record window.
    dwell_ticks = 16'd6;
    exp_q.push_back(req_ev(0));
    exp_q.push_back(ev(EvSet, 28'(SETTLE)));
    exp_q.push_back(ev(EvRec, 28'd3));
    exp_q.push_back(ev(EvRst, 28'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(0, 1'b1, "abort2_wait_req");
    synth_ack = 1'b1;
    tick();
    synth_ack = 1'b0;
    do_lock(0);
    wait_until(1, 1'b1, "abort2_wait_record");
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort2_rx_record", 32'(rx_record), 32'd0);

`ifdef FSQ_LOCK_TIMEOUT_EN
    exp_q.push_back(req_ev(0));
    exp_q.push_back(ev(EvRst, 28'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_until(0, 1'b1, "tmo_wait_req");
    pll_locked = 1'b0;
    synth_ack  = 1'b1;
    tick();
    synth_ack  = 1'b0;
    repeat (19) tick();
    check("tmo_still_busy", 32'(busy), 32'd1);
    tick();
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_lock_err", 32'(lock_err), 32'd1);
    check("tmo_rx_reset", 32'(rx_reset), 32'd1);
    model_tbl[0] = 16'h0abc;
    cfg_we   = 1'b1;
    cfg_addr = 2'd0;
    cfg_word = 16'h0abc;
    tick();
    cfg_we = 1'b0;
    exp_q.push_back(req_ev(0));
    exp_q.push_back(ev(EvRst, 28'd0));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tmo_err_cleared", 32'(lock_err), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    pll_locked = 1'b1;
`else
    check("lock_err_tied", 32'(lock_err), 32'd0);
`endif

    repeat (4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
